// File: rtl/pe_module.sv
// Systolic-array multiply-accumulate PE: out += a*b each cycle, operands forwarded east/south.
// Define PE_SAT_EN for a saturating, sticky accumulator; the default build wraps modulo 2^ACC_W.
module pe_module #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  out,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  localparam int PROD_W = 2 * DATA_W;
  // One guard bit above the wider of accumulator and product, so the true sum never overflows.
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic [ACC_W-1:0]  out_q, out_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

`ifdef PE_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    sum     = SUM_W'(out_q) + SUM_W'(prod);
    out_a_d = a;
    out_b_d = b;
    sat_d   = sat_q;
    out_d   = sum[ACC_W-1:0];
    if (sat_q || (sum > SUM_W'({ACC_W{1'b1}}))) begin
      sat_d = 1'b1;
      out_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  logic unused_sum_hi;

  always_comb begin
    prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    sum     = SUM_W'(out_q) + SUM_W'(prod);
    out_a_d = a;
    out_b_d = b;
    out_d   = sum[ACC_W-1:0];
  end

  // Bits above ACC_W are dropped by the modulo reduction.
  assign unused_sum_hi = ^sum[SUM_W-1:ACC_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_q   <= out_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign out   = out_q;
  assign out_a = out_a_q;
  assign out_b = out_b_q;

endmodule

// File: tb/tb_pe_module.sv
// Scoreboard bench for pe_module: driver queues hand-computed expectations, monitor checks each edge.
module tb_pe_module;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic [7:0] out_a;
  logic [7:0] out_b;

  int n_cmp;
  int n_bad;

  typedef struct {
    string      name;
    logic [7:0] eo;
    logic [7:0] ea;
    logic [7:0] eb;
  } exp_t;

  exp_t sb_q[$];

  pe_module #(.DATA_W(8), .ACC_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .out   (out),
    .out_a (out_a),
    .out_b (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input string field,
                                input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %02h required %02h", name, field, got, exp);
    end
  endfunction

  // Monitor: the PE presents a result every edge; compare whenever one is expected.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, "out",   out,   e.eo);
        check(e.name, "out_a", out_a, e.ea);
        check(e.name, "out_b", out_b, e.eb);
      end
    end
  end

  task automatic step(input string name, input logic r, input logic [7:0] av,
                      input logic [7:0] bv, input logic [7:0] eo,
                      input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    e.name = name;
    e.eo   = eo;
    e.ea   = ea;
    e.eb   = eb;
    sb_q.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    a   = 8'h00;
    b   = 8'h00;

    step("rst_x",   1'b1, 8'hxx, 8'hxx, 8'd0, 8'd0, 8'd0);
    step("acc0",    1'b0, 8'd2,  8'd1,  8'd2,  8'd2, 8'd1);
    step("acc1",    1'b0, 8'd7,  8'd1,  8'd9,  8'd7, 8'd1);
    step("acc2",    1'b0, 8'd4,  8'd1,  8'd13, 8'd4, 8'd1);
    step("acc3",    1'b0, 8'd5,  8'd3,  8'd28, 8'd5, 8'd3);
    step("acc4",    1'b0, 8'd4,  8'd1,  8'd32, 8'd4, 8'd1);
    step("acc5",    1'b0, 8'd4,  8'd0,  8'd32, 8'd4, 8'd0);
    step("acc6",    1'b0, 8'd8,  8'd4,  8'd64, 8'd8, 8'd4);
    step("acc7",    1'b0, 8'd7,  8'd2,  8'd78, 8'd7, 8'd2);
    step("acc8",    1'b0, 8'd2,  8'd2,  8'd82, 8'd2, 8'd2);

    step("rst_a",   1'b1, 8'd9,  8'd9,  8'd0, 8'd0, 8'd0);
    step("rst_b",   1'b1, 8'd3,  8'd4,  8'd0, 8'd0, 8'd0);
`ifdef PE_SAT_EN
    step("sat0",    1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    step("sat1",    1'b0, 8'd0,   8'd0,   8'd255, 8'd0,   8'd0);
    step("sat2",    1'b0, 8'd1,   8'd1,   8'd255, 8'd1,   8'd1);
    step("sat_rst", 1'b1, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0);
    step("sat3",    1'b0, 8'd3,   8'd3,   8'd9,   8'd3,   8'd3);
`else
    step("wrap0",   1'b0, 8'd255, 8'd255, 8'd1, 8'd255, 8'd255);
    step("wrap1",   1'b0, 8'd16,  8'd16,  8'd1, 8'd16,  8'd16);
    step("wrap2",   1'b0, 8'd200, 8'd2,   8'd145, 8'd200, 8'd2);
`endif

    step("mid_rst", 1'b1, 8'd0,  8'd0,  8'd0,  8'd0, 8'd0);
    step("mid0",    1'b0, 8'd2,  8'd1,  8'd2,  8'd2, 8'd1);
    step("mid1",    1'b0, 8'd7,  8'd1,  8'd9,  8'd7, 8'd1);
    step("mid2",    1'b0, 8'd4,  8'd1,  8'd13, 8'd4, 8'd1);
    step("mid3",    1'b0, 8'd5,  8'd3,  8'd28, 8'd5, 8'd3);
    step("mid4",    1'b1, 8'd5,  8'd5,  8'd0,  8'd0, 8'd0);
    step("mid5",    1'b0, 8'd3,  8'd3,  8'd9,  8'd3, 8'd3);

    step("pt_rst",  1'b1, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0);
    step("pt_idle", 1'b0, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0);
`ifdef PE_SAT_EN
    step("pt0",     1'b0, 8'hA5, 8'h5A, 8'd255, 8'hA5, 8'h5A);
    step("pt1",     1'b0, 8'h00, 8'h00, 8'd255, 8'h00, 8'h00);
`else
    step("pt0",     1'b0, 8'hA5, 8'h5A, 8'd2,   8'hA5, 8'h5A);
    step("pt1",     1'b0, 8'h00, 8'h00, 8'd2,   8'h00, 8'h00);
`endif

    for (int unsigned i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
